// File: rtl/vi_sync_pp_sched_pkg.sv
// -----------------------------------------------------------------------------
// vi_sync_pp_sched_pkg
// Shared types and constants for the slow-status slot scheduler that feeds the
// pulse-pair sampling synchronizer.
//   sched_state_e       : scheduler FSM encoding (IDLE -> LOAD -> HOLD -> IDLE)
//   SYNC_SAMPLE_PERIOD  : sample period of the downstream periodic sampler, clks
//   MIN_HOLD            : shortest legal hold so the sampler captures the word
//                         at least twice with one clock of margin on each side
// -----------------------------------------------------------------------------
package vi_sync_pp_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2
    } sched_state_e;

    localparam int SYNC_SAMPLE_PERIOD = 33;
    localparam int MIN_HOLD           = 2 * SYNC_SAMPLE_PERIOD + 2;

endpackage : vi_sync_pp_sched_pkg

// File: rtl/vi_sync_pp_sched_arb.sv
// -----------------------------------------------------------------------------
// vi_rr_arb
// Combinational round-robin picker. Searches upward starting one position past
// ptr, wrapping N-1 -> 0, and returns the first requester found.
// Ports:
//   req     in  N    request vector
//   ptr     in  IW   last granted index (search starts at ptr+1)
//   winner  out IW   index of the selected requester (0 when none)
//   any     out 1    at least one request is set
// -----------------------------------------------------------------------------
module vi_rr_arb #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] winner,
    output logic          any
);

    logic [IW-1:0] w_cand;

    always_comb begin
        // NOTE: every output gets a default before the search, so no path
        // leaves a variable unassigned and no latch is inferred.
        winner = '0;
        any    = 1'b0;
        w_cand = '0;
        // Offsets 1..N visit every requester once; offset N lands on ptr
        // itself, so the last granted requester has the lowest priority.
        for (int k = 1; k <= N; k++) begin
            w_cand = IW'((int'(ptr) + k) % N);
            if (!any && req[w_cand]) begin
                any    = 1'b1;
                winner = w_cand;
            end
        end
    end

endmodule : vi_rr_arb

// File: rtl/vi_sync_pp_sched.sv
// -----------------------------------------------------------------------------
// vi_sync_pp_sched
// Time-slot scheduler sharing one slow-status CDC sampling channel among
// NUM_REQ requesters. A round-robin winner's word is loaded onto chan_bus with
// its id and a toggling sequence bit, then held for HOLD_CYCLES so the periodic
// sampler downstream (33-clk period) captures it. The destination demuxes by id
// and detects fresh words by a change of seq.
// Ports:
//   clk       in   1                 clock
//   rst       in   1                 synchronous active-high reset
//   en        in   1                 permits starting new slots (IDLE->LOAD only)
//   req       in   NUM_REQ           level requests, held until gnt
//   req_data  in   NUM_REQ*DATA_W    requester i data at [i*DATA_W +: DATA_W]
//   gnt       out  NUM_REQ           one-cycle one-hot: word i was latched
//   chan_bus  out  1+ID_W+DATA_W     registered {seq, id, data}
//   busy      out  1                 scheduler not in IDLE
// -----------------------------------------------------------------------------
module vi_sync_pp_sched
    import vi_sync_pp_sched_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 16,
    parameter int HOLD_CYCLES = 72
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          gnt,
    output logic [$clog2(NUM_REQ)+DATA_W:0] chan_bus,
    output logic                        busy
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(HOLD_CYCLES);
    localparam int BUS_W = 1 + ID_W + DATA_W;

    // Parameter sanity: a shorter hold lets the sampler miss a word.
    if (HOLD_CYCLES < MIN_HOLD) begin : g_bad_hold
        $error("vi_sync_pp_sched: HOLD_CYCLES=%0d below minimum %0d", HOLD_CYCLES, MIN_HOLD);
    end
    if (NUM_REQ < 2) begin : g_bad_num_req
        $error("vi_sync_pp_sched: NUM_REQ=%0d must be at least 2", NUM_REQ);
    end

    sched_state_e        r_state;
    logic [ID_W-1:0]     r_sel;
    logic [ID_W-1:0]     r_rr_ptr;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_seq;
    logic [NUM_REQ-1:0]  r_gnt;
    logic [BUS_W-1:0]    r_chan;
    logic                r_busy;

    logic [ID_W-1:0]     w_winner;
    logic                w_any;
    logic [DATA_W-1:0]   w_lane [NUM_REQ];
    logic [DATA_W-1:0]   w_sel_data;
    logic [NUM_REQ-1:0]  w_sel_onehot;

    // Unpack the flat data bus into lanes so the selected one is a plain index.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        assign w_lane[i] = req_data[i*DATA_W +: DATA_W];
    end

    assign w_sel_data   = w_lane[r_sel];
    assign w_sel_onehot = NUM_REQ'(1) << r_sel;

    vi_rr_arb #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_arb (
        .req    (req),
        .ptr    (r_rr_ptr),
        .winner (w_winner),
        .any    (w_any)
    );

    always_ff @(posedge clk) begin
        // NOTE: all state here uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            r_state  <= IDLE;
            r_sel    <= '0;
            r_rr_ptr <= ID_W'(NUM_REQ - 1);
            r_cnt    <= '0;
            r_seq    <= 1'b0;
            r_gnt    <= '0;
            r_chan   <= '0;
            r_busy   <= 1'b0;
        end else begin
            // gnt is a single-cycle pulse; only LOAD raises it.
            r_gnt <= '0;
            case (r_state)
                IDLE: begin
                    if (en && w_any) begin
                        r_sel   <= w_winner;
                        r_state <= LOAD;
                        r_busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    // Requester may have withdrawn between arbitration and
                    // load; in that case nothing visible changes.
                    if (req[r_sel]) begin
                        r_chan   <= {~r_seq, r_sel, w_sel_data};
                        r_seq    <= ~r_seq;
                        r_gnt    <= w_sel_onehot;
                        r_rr_ptr <= r_sel;
                        r_cnt    <= CNT_W'(HOLD_CYCLES - 1);
                        r_state  <= HOLD;
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                HOLD: begin
                    // Counts HOLD_CYCLES-1 down to 0, leaving after the zero
                    // cycle: exactly HOLD_CYCLES cycles spent in HOLD.
                    if (r_cnt == '0) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt      = r_gnt;
    assign chan_bus = r_chan;
    assign busy     = r_busy;

endmodule : vi_sync_pp_sched

// File: tb/tb_vi_sync_pp_sched.sv
module tb_vi_sync_pp_sched;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int HC = 72;
    localparam int IW = 2;
    localparam int BW = 1 + IW + DW;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en  = 1'b0;
    logic [N-1:0]      req = '0;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      gnt;
    logic [BW-1:0]     chan_bus;
    logic              busy;

    logic [DW-1:0]     lanes [N];

    always #5 clk = ~clk;

    always_comb begin
        req_data = '0;
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = lanes[i];
    end

    vi_sync_pp_sched #(
        .NUM_REQ     (N),
        .DATA_W      (DW),
        .HOLD_CYCLES (HC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .req      (req),
        .req_data (req_data),
        .gnt      (gnt),
        .chan_bus (chan_bus),
        .busy     (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Transaction-level reference: last granted id, seq bit, expected bus word.
    int            m_last;
    bit            m_seq;
    logic [BW-1:0] m_bus;

    task automatic model_reset();
        m_last = N - 1;
        m_seq  = 1'b0;
        m_bus  = '0;
    endtask

    // Round-robin rule: first requester after the last granted one, wrapping.
    function automatic int m_winner(input logic [N-1:0] mask);
        for (int k = 1; k <= N; k++) begin
            if (mask[(m_last + k) % N]) return (m_last + k) % N;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic wait_gnt(input int budget, output int cycles, output bit ok);
        cycles = 0;
        ok     = 1'b0;
        while (cycles < budget) begin
            tick();
            cycles++;
            if (gnt != '0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(input string tag, input int budget, output int cycles);
        cycles = 0;
        while (busy && cycles < budget) begin
            tick();
            cycles++;
        end
        if (busy) check({tag, "_idle_timeout"}, 64'(busy), 64'(0));
    endtask

    // Waits for the next grant and compares it with the model's prediction.
    task automatic expect_grant(input string tag, input logic [N-1:0] mask,
                                input int exp_lat, input int budget, output int w);
        int cyc;
        bit ok;
        w = m_winner(mask);
        wait_gnt(budget, cyc, ok);
        check({tag, "_seen"}, 64'(ok), 64'(1));
        if (ok) begin
            if (exp_lat >= 0) check({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
            m_seq  = ~m_seq;
            m_bus  = {m_seq, IW'(w), lanes[w]};
            m_last = w;
            check({tag, "_gnt"}, 64'(gnt), 64'(1) << w);
            check({tag, "_bus"}, 64'(chan_bus), 64'(m_bus));
            check({tag, "_busy"}, 64'(busy), 64'(1));
        end
    endtask

    // Continuous protocol checks sampled on the falling edge.
    logic [BW-1:0] mon_prev;
    int            mon_since;
    bit            mon_loaded;

    always @(negedge clk) begin
        check("gnt_onehot0", 64'($onehot0(gnt)), 64'(1));
        if (rst) begin
            mon_prev   <= chan_bus;
            mon_since  <= 0;
            mon_loaded <= 1'b0;
        end else if (chan_bus !== mon_prev) begin
            check("bus_chg_with_gnt", 64'(gnt != '0), 64'(1));
            if (mon_loaded) check("bus_stable_len", 64'(mon_since + 1 >= HC + 1), 64'(1));
            mon_prev   <= chan_bus;
            mon_since  <= 0;
            mon_loaded <= 1'b1;
        end else begin
            mon_since <= mon_since + 1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int cyc;
        bit seen;
        logic [N-1:0] mask;

        for (int i = 0; i < N; i++) lanes[i] = '0;
        model_reset();

        // Reset state
        do_reset();
        check("rst_gnt", 64'(gnt), 64'(0));
        check("rst_bus", 64'(chan_bus), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));

        // Single requester, directed word
        en       = 1'b1;
        lanes[0] = 16'hA5A5;
        req      = 4'b0001;
        expect_grant("t1", req, 2, 10, w);
        check("t1_bus_lit", 64'(chan_bus), 64'(19'h4A5A5));
        req = '0;
        wait_idle("t1", 200, cyc);

        // Fairness: all requests held, fresh pointer after reset
        do_reset();
        for (int i = 0; i < N; i++) lanes[i] = DW'($urandom);
        req = 4'b1111;
        expect_grant("rr0", req, 2, 10, w);
        for (int g = 1; g < 5; g++) begin
            expect_grant($sformatf("rr%0d", g), req, HC + 2, HC + 10, w);
        end
        req = '0;
        wait_idle("rr", 200, cyc);

        // Abort: requester withdraws during LOAD
        lanes[2] = DW'($urandom);
        req = 4'b0100;
        tick();
        req = '0;
        tick();
        check("abort_gnt", 64'(gnt), 64'(0));
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_bus", 64'(chan_bus), 64'(m_bus));
        req = 4'b1111;
        expect_grant("post_abort", req, 2, 10, w);
        req = '0;
        wait_idle("post_abort", 200, cyc);

        // Reset in the middle of HOLD
        lanes[0] = DW'($urandom);
        req = 4'b0001;
        expect_grant("mid_rst_pre", req, 2, 10, w);
        req = '0;
        repeat (41) tick();
        rst = 1'b1;
        tick();
        check("mid_rst_bus", 64'(chan_bus), 64'(0));
        check("mid_rst_gnt", 64'(gnt), 64'(0));
        check("mid_rst_busy", 64'(busy), 64'(0));
        tick();
        rst = 1'b0;
        model_reset();
        lanes[3] = DW'($urandom);
        req = 4'b1000;
        expect_grant("mid_rst_r3", req, 2, 10, w);
        req = '0;
        wait_idle("mid_rst_r3", 200, cyc);
        req = 4'b1111;
        expect_grant("mid_rst_next", req, 2, 10, w);
        req = '0;
        wait_idle("mid_rst_next", 200, cyc);

        // en gating
        en       = 1'b0;
        lanes[1] = DW'($urandom);
        req      = 4'b0010;
        seen     = 1'b0;
        for (int c = 0; c < 200; c++) begin
            tick();
            if (gnt != '0 || busy) seen = 1'b1;
        end
        check("en0_no_gnt", 64'(seen), 64'(0));
        en = 1'b1;
        expect_grant("en1", req, 2, 10, w);
        req = '0;
        repeat (10) tick();
        en = 1'b0;
        wait_idle("en0_hold", 200, cyc);
        check("en0_hold_len", 64'(10 + cyc), 64'(HC));

        // en dropped during LOAD does not abort
        en       = 1'b1;
        lanes[0] = DW'($urandom);
        req      = 4'b0001;
        tick();
        en = 1'b0;
        expect_grant("en_load", req, 1, 1, w);
        req = '0;
        wait_idle("en_load", 200, cyc);
        en = 1'b1;

        // Randomized slots with occasional aborts
        for (int it = 0; it < 25; it++) begin
            for (int i = 0; i < N; i++) lanes[i] = DW'($urandom);
            mask = N'($urandom_range(1, (1 << N) - 1));
            req  = mask;
            if ($urandom_range(0, 3) == 0) begin
                tick();
                req = '0;
                tick();
                check($sformatf("rnd%0d_abort_gnt", it), 64'(gnt), 64'(0));
                check($sformatf("rnd%0d_abort_bus", it), 64'(chan_bus), 64'(m_bus));
            end else begin
                expect_grant($sformatf("rnd%0d", it), mask, 2, 10, w);
                req = '0;
                wait_idle($sformatf("rnd%0d", it), 200, cyc);
            end
        end

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_vi_sync_pp_sched
